// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register with valid/ready handshake, an optional
// two-entry skid buffer, flush with bubble injection and saturating
// stall / flush-drop statistics counters.
module pipe_stage_reg #(
  parameter int                   DATA_W     = 64,
  parameter logic [DATA_W-1:0]    BUBBLE_VAL = '0,
  parameter bit                   SKID_EN    = 1'b1,
  parameter int                   CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              flush_i,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_drop_cnt_o
);

  // EMPTY: nothing held. BUSY: main entry held. FULL: main + skid held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic                in_fire;
  logic                out_fire;
  logic [1:0]          held_n;
  logic [1:0]          drop_n;
  logic [CNT_W+1:0]    drop_sum;

  // The head of the queue is always the main entry; the bubble value is
  // substituted whenever nothing valid is presented downstream.
  assign valid_o  = (state_q != ST_EMPTY);
  assign data_o   = valid_o ? main_q : BUBBLE_VAL;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // ready_o generation depends on whether the skid buffer exists.
  generate
    if (SKID_EN) begin : g_skid_ready
      logic ready_q, ready_d;

      // ready_o is registered: it only depends on the next state, which
      // breaks any combinational ready_i -> ready_o path.
      always_comb begin
        ready_d = (state_d != ST_FULL);
      end

      // Registered ready flop, high out of reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= ready_d;
        end
      end

      assign ready_o = ready_q;
    end else begin : g_comb_ready
      // Single entry: accept when empty or when the held entry leaves now.
      assign ready_o = ~valid_o | ready_i;
    end
  endgenerate

  // Next-state and payload movement; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_BUSY;
            main_d  = data_i;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = data_i;
          end else if (in_fire && !out_fire) begin
            // Only reachable with the skid buffer: without it ready_o is
            // low whenever the held entry is stalled.
            if (SKID_EN) begin
              state_d = ST_FULL;
              skid_d  = data_i;
            end
          end else if (!in_fire && out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // ready_o is low here, so only the drain side can move.
          if (out_fire) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Number of valid entries lost to a flush this cycle: held entries not
  // delivered downstream, plus an incoming payload that was accepted.
  always_comb begin
    held_n = 2'd0;
    case (state_q)
      ST_BUSY: held_n = 2'd1;
      ST_FULL: held_n = 2'd2;
      default: held_n = 2'd0;
    endcase
    drop_n   = held_n - {1'b0, out_fire} + {1'b0, in_fire};
    drop_sum = (CNT_W+2)'(drop_cnt_q) + (CNT_W+2)'(drop_n);
  end

  // Saturating statistics counters; clear wins over any increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (cnt_clr_i) begin
      stall_cnt_d = '0;
      drop_cnt_d  = '0;
    end else begin
      if (valid_o && !ready_i && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush_i) begin
        if (drop_sum > (CNT_W+2)'(CNT_MAX)) begin
          drop_cnt_d = CNT_MAX;
        end else begin
          drop_cnt_d = drop_sum[CNT_W-1:0];
        end
      end
    end
  end

  // State, payload and counter registers; reset discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE_VAL;
      skid_q      <= BUBBLE_VAL;
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign stall_cnt_o      = stall_cnt_q;
  assign flush_drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid-buffered instance (A), a
// skid-buffered instance with 4-bit counters (B) and a single-entry
// instance (C), all sharing clock and reset.
module tb_pipe_stage_reg;

  localparam int DW = 8;
  localparam logic [DW-1:0] BUB_A = 8'h13;
  localparam logic [DW-1:0] BUB_B = 8'hEE;
  localparam logic [DW-1:0] BUB_C = 8'h5A;

  logic clk;
  logic rst_n;

  logic          a_valid_i, a_ready_o, a_valid_o, a_ready_i, a_flush_i, a_cnt_clr_i;
  logic [DW-1:0] a_data_i, a_data_o;
  logic [15:0]   a_stall, a_drop;

  logic          b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_flush_i, b_cnt_clr_i;
  logic [DW-1:0] b_data_i, b_data_o;
  logic [3:0]    b_stall, b_drop;

  logic          c_valid_i, c_ready_o, c_valid_o, c_ready_i, c_flush_i, c_cnt_clr_i;
  logic [DW-1:0] c_data_i, c_data_o;
  logic [15:0]   c_stall, c_drop;

  int tests;
  int failed;

  pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB_A), .SKID_EN(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .valid_i(a_valid_i), .ready_o(a_ready_o), .data_i(a_data_i),
    .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o),
    .flush_i(a_flush_i), .cnt_clr_i(a_cnt_clr_i),
    .stall_cnt_o(a_stall), .flush_drop_cnt_o(a_drop)
  );

  pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB_B), .SKID_EN(1'b1), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
    .flush_i(b_flush_i), .cnt_clr_i(b_cnt_clr_i),
    .stall_cnt_o(b_stall), .flush_drop_cnt_o(b_drop)
  );

  pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB_C), .SKID_EN(1'b0), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n),
    .valid_i(c_valid_i), .ready_o(c_ready_o), .data_i(c_data_i),
    .valid_o(c_valid_o), .ready_i(c_ready_i), .data_o(c_data_o),
    .flush_i(c_flush_i), .cnt_clr_i(c_cnt_clr_i),
    .stall_cnt_o(c_stall), .flush_drop_cnt_o(c_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid_i = 0; a_ready_i = 0; a_data_i = '0; a_flush_i = 0; a_cnt_clr_i = 0;
    b_valid_i = 0; b_ready_i = 0; b_data_i = '0; b_flush_i = 0; b_cnt_clr_i = 0;
    c_valid_i = 0; c_ready_i = 0; c_data_i = '0; c_flush_i = 0; c_cnt_clr_i = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
    tests++;
    if (a_valid_o !== 1'b0 || a_data_o !== BUB_A || a_ready_o !== 1'b1) begin
      failed++;
      $display("FAIL reset_outputs: valid=%b data=%h ready=%b, want 0 %h 1", a_valid_o, a_data_o, a_ready_o, BUB_A);
    end
    tests++;
    if (a_stall !== 16'd0 || a_drop !== 16'd0) begin
      failed++;
      $display("FAIL reset_counters: stall=%0d drop=%0d, want 0 0", a_stall, a_drop);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_streaming();
    logic [DW-1:0] vec [3];
    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33;
    a_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_valid_i = 1'b1;
      a_data_i  = vec[i];
      step();
      $display("[TB] stream push %h -> out valid=%b data=%h", vec[i], a_valid_o, a_data_o);
      tests++;
      if (a_valid_o !== 1'b1 || a_data_o !== vec[i] || a_ready_o !== 1'b1) begin
        failed++;
        $display("FAIL stream_%0d: valid=%b data=%h ready=%b, want 1 %h 1", i, a_valid_o, a_data_o, a_ready_o, vec[i]);
      end
    end
    a_valid_i = 1'b0;
    step();
    tests++;
    if (a_valid_o !== 1'b0 || a_data_o !== BUB_A || a_stall !== 16'd0) begin
      failed++;
      $display("FAIL stream_drain: valid=%b data=%h stall=%0d, want 0 %h 0", a_valid_o, a_data_o, a_stall, BUB_A);
    end
  endtask

  task automatic test_backpressure();
    a_ready_i = 1'b0;
    a_valid_i = 1'b1; a_data_i = 8'hA1;
    step();
    tests++;
    if (a_valid_o !== 1'b1 || a_data_o !== 8'hA1 || a_ready_o !== 1'b1) begin
      failed++;
      $display("FAIL bp_first: valid=%b data=%h ready=%b, want 1 a1 1", a_valid_o, a_data_o, a_ready_o);
    end
    a_data_i = 8'hA2;
    step();
    tests++;
    if (a_ready_o !== 1'b0 || a_data_o !== 8'hA1) begin
      failed++;
      $display("FAIL bp_full: ready=%b data=%h, want 0 a1", a_ready_o, a_data_o);
    end
    a_data_i = 8'hA3;
    step(); step(); step();
    $display("[TB] backpressure held, stall=%0d", a_stall);
    tests++;
    if (a_stall !== 16'd4 || a_ready_o !== 1'b0 || a_data_o !== 8'hA1) begin
      failed++;
      $display("FAIL bp_stall4: stall=%0d ready=%b data=%h, want 4 0 a1", a_stall, a_ready_o, a_data_o);
    end
    a_ready_i = 1'b1;
    step();
    tests++;
    if (a_data_o !== 8'hA2 || a_ready_o !== 1'b1 || a_valid_o !== 1'b1) begin
      failed++;
      $display("FAIL bp_second: data=%h ready=%b valid=%b, want a2 1 1", a_data_o, a_ready_o, a_valid_o);
    end
    step();
    tests++;
    if (a_data_o !== 8'hA3 || a_valid_o !== 1'b1) begin
      failed++;
      $display("FAIL bp_third: data=%h valid=%b, want a3 1", a_data_o, a_valid_o);
    end
    a_valid_i = 1'b0;
    step();
    tests++;
    if (a_valid_o !== 1'b0 || a_stall !== 16'd4) begin
      failed++;
      $display("FAIL bp_done: valid=%b stall=%0d, want 0 4", a_valid_o, a_stall);
    end
  endtask

  task automatic test_flush();
    // Flush a stalled single entry: one drop.
    a_ready_i = 1'b0;
    a_valid_i = 1'b1; a_data_i = 8'hB1;
    step();
    a_valid_i = 1'b0; a_flush_i = 1'b1;
    step();
    a_flush_i = 1'b0;
    tests++;
    if (a_drop !== 16'd1 || a_valid_o !== 1'b0) begin
      failed++;
      $display("FAIL flush_busy: drop=%0d valid=%b, want 1 0", a_drop, a_valid_o);
    end
    // Fill to FULL, flush with an upstream payload pending: two more drops.
    a_valid_i = 1'b1; a_data_i = 8'hC1;
    step();
    a_data_i = 8'hC2;
    step();
    a_data_i = 8'hC3; a_flush_i = 1'b1;
    step();
    a_flush_i = 1'b0; a_valid_i = 1'b0;
    $display("[TB] flush in full -> valid=%b data=%h ready=%b drop=%0d", a_valid_o, a_data_o, a_ready_o, a_drop);
    tests++;
    if (a_valid_o !== 1'b0 || a_data_o !== BUB_A || a_ready_o !== 1'b1 || a_drop !== 16'd3) begin
      failed++;
      $display("FAIL flush_full: valid=%b data=%h ready=%b drop=%0d, want 0 %h 1 3", a_valid_o, a_data_o, a_ready_o, a_drop, BUB_A);
    end
    tests++;
    if (a_stall !== 16'd7) begin
      failed++;
      $display("FAIL flush_stall: stall=%0d, want 7", a_stall);
    end
  endtask

  task automatic test_flush_out_fire();
    a_ready_i = 1'b1;
    a_valid_i = 1'b1; a_data_i = 8'hD1;
    step();
    a_valid_i = 1'b0; a_flush_i = 1'b1;
    step();
    a_flush_i = 1'b0;
    tests++;
    if (a_drop !== 16'd3 || a_valid_o !== 1'b0) begin
      failed++;
      $display("FAIL flush_outfire: drop=%0d valid=%b, want 3 0", a_drop, a_valid_o);
    end
    // Emitted entry not counted, accepted incoming entry is.
    a_valid_i = 1'b1; a_data_i = 8'hE1;
    step();
    a_data_i = 8'hE2; a_flush_i = 1'b1;
    step();
    a_flush_i = 1'b0; a_valid_i = 1'b0;
    tests++;
    if (a_drop !== 16'd4 || a_valid_o !== 1'b0 || a_data_o !== BUB_A) begin
      failed++;
      $display("FAIL flush_infire: drop=%0d valid=%b data=%h, want 4 0 %h", a_drop, a_valid_o, a_data_o, BUB_A);
    end
  endtask

  task automatic test_saturation();
    b_ready_i = 1'b0;
    b_valid_i = 1'b1; b_data_i = 8'h05;
    step();
    b_valid_i = 1'b0;
    for (int i = 0; i < 14; i++) step();
    tests++;
    if (b_stall !== 4'd14) begin
      failed++;
      $display("FAIL sat_count14: stall=%0d, want 14", b_stall);
    end
    for (int i = 0; i < 6; i++) step();
    $display("[TB] saturation after 20 stall cycles stall=%0d", b_stall);
    tests++;
    if (b_stall !== 4'd15) begin
      failed++;
      $display("FAIL sat_hold: stall=%0d, want 15", b_stall);
    end
    b_cnt_clr_i = 1'b1;
    step();
    b_cnt_clr_i = 1'b0;
    tests++;
    if (b_stall !== 4'd0) begin
      failed++;
      $display("FAIL sat_clear: stall=%0d, want 0", b_stall);
    end
    step();
    tests++;
    if (b_stall !== 4'd1 || b_data_o !== 8'h05) begin
      failed++;
      $display("FAIL sat_resume: stall=%0d data=%h, want 1 05", b_stall, b_data_o);
    end
    b_ready_i = 1'b1;
    step();
    tests++;
    if (b_valid_o !== 1'b0 || b_data_o !== BUB_B) begin
      failed++;
      $display("FAIL sat_drain: valid=%b data=%h, want 0 %h", b_valid_o, b_data_o, BUB_B);
    end
  endtask

  task automatic test_no_skid();
    c_ready_i = 1'b1;
    c_valid_i = 1'b1; c_data_i = 8'h31;
    step();
    tests++;
    if (c_valid_o !== 1'b1 || c_data_o !== 8'h31 || c_ready_o !== 1'b1) begin
      failed++;
      $display("FAIL noskid_first: valid=%b data=%h ready=%b, want 1 31 1", c_valid_o, c_data_o, c_ready_o);
    end
    c_data_i = 8'h32;
    c_ready_i = 1'b0;
    #1;
    tests++;
    if (c_ready_o !== 1'b0) begin
      failed++;
      $display("FAIL noskid_ready_low: ready=%b, want 0", c_ready_o);
    end
    step();
    tests++;
    if (c_data_o !== 8'h31 || c_stall !== 16'd1) begin
      failed++;
      $display("FAIL noskid_hold: data=%h stall=%0d, want 31 1", c_data_o, c_stall);
    end
    c_ready_i = 1'b1;
    #1;
    tests++;
    if (c_ready_o !== 1'b1) begin
      failed++;
      $display("FAIL noskid_ready_high: ready=%b, want 1", c_ready_o);
    end
    step();
    $display("[TB] no-skid replace -> data=%h", c_data_o);
    tests++;
    if (c_data_o !== 8'h32 || c_valid_o !== 1'b1) begin
      failed++;
      $display("FAIL noskid_replace: data=%h valid=%b, want 32 1", c_data_o, c_valid_o);
    end
    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (c_valid_o !== 1'b0 || c_data_o !== BUB_C || c_stall !== 16'd0) begin
      failed++;
      $display("FAIL noskid_async_rst: valid=%b data=%h stall=%0d, want 0 %h 0", c_valid_o, c_data_o, c_stall, BUB_C);
    end
    c_valid_i = 1'b0;
    rst_n = 1'b1;
    step();
    tests++;
    if (c_valid_o !== 1'b0 || c_ready_o !== 1'b1) begin
      failed++;
      $display("FAIL noskid_after_rst: valid=%b ready=%b, want 0 1", c_valid_o, c_ready_o);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_out_fire();
    test_saturation();
    test_no_skid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
